imm_pack: RTL
=============

Name: imm_pack

Overview:
- Inverse of the immediate generator: takes an instruction template plus a 32-bit immediate value, range-checks it, and scatters its bits into the instruction fields for the selected format.
- Also expands a "load immediate" pseudo-op into a LUI+ADDI pair, which makes the block multi-cycle.
- Sits in the debug/program-buffer path, where the boot loader and debug module build RISC-V instructions on the fly.
- Valid/ready on both sides; single registered output stage.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_sel  in  3  format: 0=I, 1=S, 2=B, 3=J, 4=U, 5=CSR, 6=LI, 7=reserved.
- in_base  in  32  instruction template; opcode/funct/register bits are kept, immediate bit positions are overwritten.
- in_imm  in  32  immediate value (byte offset for B/J, full 32-bit value for U/LI).
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.
- out_inst  out  32  encoded instruction.
- out_err  out  1  qualifies out_inst: immediate was out of range or misaligned.
- err_cnt  out  ERR_CNT_W  count of words emitted with out_err=1; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_inst=0, out_err=0, err_cnt=0, FSM=IDLE.
  - in_ready is 0 while rst_n=0.
- Reset mid-LI drops the pending second word.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Latency: an accepted request appears on out_inst on the next rising edge.
- Output hold: out_inst/out_err hold stable while out_valid && !out_ready.
- Field packing (bits not listed come from in_base):
  - I: [31:20]=imm[11:0]. err if imm is not the sign-extension of imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range rule as I.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. err if imm is not the sign-extension of imm[12:0], or imm[0]=1.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. err if imm is not the sign-extension of imm[20:0], or imm[0]=1.
  - U: [31:12]=imm[31:12]. err if imm[11:0]!=0.
  - CSR: [19:15]=imm[4:0]. err if imm[31:5]!=0.
  - reserved (7): out_inst=in_base unmodified, err=1.
- On error the word is still emitted with truncated fields.
- LI (rd=in_base[11:7]; all other in_base bits ignored):
  - lo = imm[11:0] as signed. hi = (imm + 32'h800)[31:12], arithmetic mod 2^32.
  - If imm fits 12-bit signed: one word, ADDI rd,x0,lo = {lo,5'd0,3'b000,rd,7'b0010011}.
  - Else if imm[11:0]==0: one word, LUI rd,hi = {hi,rd,7'b0110111}.
  - Else two words: LUI rd,hi, then ADDI rd,rd,lo = {lo,rd,3'b000,rd,7'b0010011}.
  - LI never sets err.
- FSM:
  - IDLE: on accept, load the output register. If LI needs two words, latch the ADDI word internally and go to EMIT2.
  - EMIT2: in_ready=0. When out_valid&&out_ready, load the ADDI word into the output register and go to IDLE.
  - The second word follows the first with zero bubble cycles when out_ready stays 1.
- err_cnt increments by 1 in the cycle an erroneous word is loaded into the output register. It holds at the max value and never wraps.

Test Plan:
- I-type: sel=0, base=32'h00000093, imm=32'hFFFFFFFF -> next cycle out_inst=32'hFFF00093, out_err=0.
- J-type: sel=3, base=32'h0000006F, imm=32'h00000800 -> out_inst=32'h0010006F, err=0.
- LI two-word: sel=6, base=32'h00000280, imm=32'h12345FFF, out_ready=1.
  - Expect 32'h123462B7 then 32'hFFF28293 on consecutive cycles.
  - in_ready=0 during the cycle of the first word.
- Misaligned B: sel=2, imm=32'h00000003 -> out_err=1, err_cnt 0->1. Then 256 more bad requests -> err_cnt stays 8'hFF.
- Backpressure: out_ready=0 for 3 cycles after an accept -> out_inst/out_err stable, in_ready=0. Release -> next request accepted that cycle.
- Reset mid-LI: rst_n=0 while in EMIT2 -> immediately out_valid=0, err_cnt=0. After release, in_ready=1 and the pending ADDI is never emitted.

Source files
------------

// File: rtl/imm_pack.sv
// imm_pack -- immediate packer for the debug / program-buffer path.
//
// Takes an instruction template plus a 32-bit immediate, range-checks the
// immediate for the selected format and scatters its bits into the
// instruction's immediate fields. Format 6 ("LI") expands a load-immediate
// pseudo-op into ADDI, LUI, or a LUI+ADDI pair. A pair takes two output
// beats, which is why the block has a small FSM.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   request handshake
//   in_sel    [2:0]  0=I 1=S 2=B 3=J 4=U 5=CSR 6=LI 7=reserved
//   in_base  [31:0]  instruction template (non-immediate bits are kept)
//   in_imm   [31:0]  immediate value
//   out_valid/ready  output handshake (single registered stage)
//   out_inst [31:0]  encoded instruction
//   out_err          immediate was out of range or misaligned
//   err_cnt          saturating count of words emitted with out_err=1
module imm_pack #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_sel,
  input  logic [31:0]          in_base,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic {S_IDLE, S_EMIT2} state_t;

  state_t                r_state;
  logic                  r_out_valid;
  logic [31:0]           r_out_inst;
  logic                  r_out_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [31:0]           r_addi;      // pending second word of an LI pair

  logic                  w_accept;
  logic [31:0]           w_inst;
  logic                  w_err;
  logic                  w_two;
  logic [31:0]           w_addi2;
  logic [4:0]            w_rd;
  logic [31:0]           w_imm_p800;
  logic                  w_fits12;
  logic                  w_fits13;
  logic                  w_fits21;

  // A value fits an N-bit signed field when every bit from N-1 upward agrees.
  assign w_fits12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign w_fits13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign w_fits21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  // LUI upper part is rounded so that the sign-extended ADDI low part
  // brings the sum back to the requested value.
  assign w_imm_p800 = in_imm + 32'h0000_0800;
  assign w_rd       = in_base[11:7];
  assign w_addi2    = {in_imm[11:0], w_rd, 3'b000, w_rd, 7'b0010011};

  always_comb begin
    w_inst = in_base;
    w_err  = 1'b0;
    w_two  = 1'b0;
    case (in_sel)
      3'd0: begin // I
        w_inst = {in_imm[11:0], in_base[19:0]};
        w_err  = !w_fits12;
      end
      3'd1: begin // S
        w_inst = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
        w_err  = !w_fits12;
      end
      3'd2: begin // B
        w_inst = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1],
                  in_imm[11], in_base[6:0]};
        w_err  = !w_fits13 || in_imm[0];
      end
      3'd3: begin // J
        w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                  in_base[11:0]};
        w_err  = !w_fits21 || in_imm[0];
      end
      3'd4: begin // U
        w_inst = {in_imm[31:12], in_base[11:0]};
        w_err  = (in_imm[11:0] != '0);
      end
      3'd5: begin // CSR (uimm in rs1 field)
        w_inst = {in_base[31:20], in_imm[4:0], in_base[14:0]};
        w_err  = (in_imm[31:5] != '0);
      end
      3'd6: begin // LI pseudo-op
        if (w_fits12) begin
          w_inst = {in_imm[11:0], 5'd0, 3'b000, w_rd, 7'b0010011};
        end else begin
          w_inst = {w_imm_p800[31:12], w_rd, 7'b0110111};
          w_two  = (in_imm[11:0] != '0);
        end
      end
      default: begin // reserved: template passes through, flagged
        w_inst = in_base;
        w_err  = 1'b1;
      end
    endcase
  end

  // rst_n term keeps in_ready low while reset is held.
  assign in_ready  = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_err   = r_out_err;
  assign err_cnt   = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_err   <= 1'b0;
      r_err_cnt   <= '0;
      r_addi      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= w_inst;
            r_out_err   <= w_err;
            if (w_err && (r_err_cnt != '1))
              r_err_cnt <= r_err_cnt + 1'b1;
            if (w_two) begin
              r_addi  <= w_addi2;
              r_state <= S_EMIT2;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_EMIT2: begin
          // Replace the LUI as it drains: no bubble between the two words.
          if (r_out_valid && out_ready) begin
            r_out_inst <= r_addi;
            r_out_err  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
